// File: rtl/tensor_mac_pkg.sv
// Shared types and sizing helpers for the tensor MAC engine.
package tensor_mac_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2
  } state_e;

  function automatic int unsigned elem_count(input int unsigned n);
    return n * n;
  endfunction

  function automatic int unsigned bytes_per_elem(input int unsigned acc_w);
    return acc_w / BYTE_W;
  endfunction

  function automatic int unsigned stream_bytes(input int unsigned n, input int unsigned acc_w);
    return elem_count(n) * bytes_per_elem(acc_w);
  endfunction

  // Full-width unsigned dot product of n byte pairs.
  function automatic int unsigned dot_width(input int unsigned n);
    return 2 * BYTE_W + $clog2(n);
  endfunction

endpackage

// File: rtl/dot_product_unit.sv
// Combinational unsigned dot product of one matrix row with one matrix column.
module dot_product_unit
  import tensor_mac_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0][BYTE_W-1:0] row_i,
  input  logic [N-1:0][BYTE_W-1:0] col_i,
  output logic [dot_width(N)-1:0]  dot_o
);

  localparam int unsigned DOT_W = dot_width(N);

  logic [DOT_W-1:0] prod [N];
  logic [DOT_W-1:0] total;

  for (genvar m = 0; m < N; m++) begin : g_prod
    assign prod[m] = DOT_W'(row_i[m]) * DOT_W'(col_i[m]);
  end

  always_comb begin
    total = '0;
    for (int m = 0; m < N; m++) begin
      total = total + prod[m];
    end
  end

  assign dot_o = total;

endmodule

// File: rtl/tensor_mac_engine.sv
// Byte-streamed NxN matrix multiply-accumulate: load A then B, compute one
// saturating accumulator element per cycle, read results back LSB-first.
module tensor_mac_engine
  import tensor_mac_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              wr_en,
  input  logic              accu_en,
  input  logic              clear,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] data_out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int unsigned NN    = elem_count(N);
  localparam int unsigned BPE   = bytes_per_elem(ACC_W);
  localparam int unsigned LD_W  = $clog2(2 * NN);
  localparam int unsigned IX_W  = $clog2(N);
  localparam int unsigned EL_W  = $clog2(NN);
  localparam int unsigned BY_W  = $clog2(BPE);
  localparam int unsigned DOT_W = dot_width(N);
  localparam int unsigned SUM_W = ((ACC_W > DOT_W) ? ACC_W : DOT_W) + 1;

  typedef logic [ACC_W-1:0] acc_t;
  localparam acc_t ACC_MAX = '1;

  state_e          state_q, state_d;
  logic [LD_W-1:0] ld_q, ld_d;
  logic [IX_W-1:0] i_q, i_d, j_q, j_d;
  logic [EL_W-1:0] k_q, k_d;
  logic [EL_W-1:0] rd_el_q, rd_el_d;
  logic [BY_W-1:0] rd_by_q, rd_by_d;
  logic            accu_q, accu_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            vld_q, vld_d;
  logic            busy_q, busy_d;
  byte_t           dout_q, dout_d;
  byte_t           a_q [NN];
  byte_t           a_d [NN];
  byte_t           b_q [NN];
  byte_t           b_d [NN];
  acc_t            acc_q [NN];
  acc_t            acc_d [NN];

  logic [N-1:0][BYTE_W-1:0] row, col;
  logic [DOT_W-1:0]         dot;
  logic [SUM_W-1:0]         sum;
  acc_t                     rd_word;
  byte_t                    rd_byte;

  // Operand gather for the element currently being computed (row i of A, column j of B).
  for (genvar m = 0; m < N; m++) begin : g_opnd
    assign row[m] = a_q[EL_W'(i_q * N + m)];
    assign col[m] = b_q[EL_W'(m * N + j_q)];
  end

  dot_product_unit #(.N(N)) u_dot (
    .row_i (row),
    .col_i (col),
    .dot_o (dot)
  );

  assign sum     = accu_q ? (SUM_W'(acc_q[k_q]) + SUM_W'(dot)) : SUM_W'(dot);
  assign rd_word = acc_q[rd_el_q];
  assign rd_byte = BYTE_W'(rd_word >> (BYTE_W * rd_by_q));

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    rd_el_d = rd_el_q;
    rd_by_d = rd_by_q;
    accu_d  = accu_q;
    ovf_d   = ovf_q;
    dout_d  = dout_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    vld_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          acc_d   = '{default: '0};
          ovf_d   = 1'b0;
          rd_el_d = '0;
          rd_by_d = '0;
        end
        // A write always wins; a read is also dropped when clear is present.
        if (wr_en) begin
          a_d[0]  = data_in;
          ld_d    = LD_W'(1);
          state_d = ST_LOAD;
        end else if (rd_en && !clear) begin
          dout_d = rd_byte;
          vld_d  = 1'b1;
          if (rd_by_q == BY_W'(BPE - 1)) begin
            rd_by_d = '0;
            rd_el_d = (rd_el_q == EL_W'(NN - 1)) ? '0 : rd_el_q + 1'b1;
          end else begin
            rd_by_d = rd_by_q + 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (wr_en) begin
          if (ld_q < LD_W'(NN)) begin
            a_d[EL_W'(ld_q)] = data_in;
          end else begin
            b_d[EL_W'(ld_q - LD_W'(NN))] = data_in;
          end
          if (ld_q == LD_W'(2 * NN - 1)) begin
            state_d = ST_COMPUTE;
            accu_d  = accu_en;
            ld_d    = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
          end else begin
            ld_d = ld_q + 1'b1;
          end
        end
      end

      ST_COMPUTE: begin
        if (sum > SUM_W'(ACC_MAX)) begin
          acc_d[k_q] = ACC_MAX;
          ovf_d      = 1'b1;
        end else begin
          acc_d[k_q] = ACC_W'(sum);
        end
        if (j_q == IX_W'(N - 1)) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        k_d = k_q + 1'b1;
        if (k_q == EL_W'(NN - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          rd_el_d = '0;
          rd_by_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      rd_el_q <= '0;
      rd_by_q <= '0;
      accu_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      acc_q   <= '{default: '0};
    end else begin
      ld_q    <= ld_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      rd_el_q <= rd_el_d;
      rd_by_q <= rd_by_d;
      accu_q  <= accu_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign data_out  = dout_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule
